// File: rtl/bus_arb_pkg.sv
`default_nettype none
// bus_arb_pkg: shared state type and default sizing for the bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int BUS_ARB_N_REQ     = 3;
  localparam int BUS_ARB_DATA_W    = 8;
  localparam int BUS_ARB_MAX_BURST = 4;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin picker; first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  assign any = |req;

  // One extra bit on the sum so ptr+k cannot overflow before the wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// bus_arbiter: round-robin sharing of one registered output bus with backpressure.
// Optional burst limit per grant is enabled by defining BUS_ARB_BURST_LIMIT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ     = BUS_ARB_N_REQ,
  parameter int DATA_W    = BUS_ARB_DATA_W,
  parameter int MAX_BURST = BUS_ARB_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  input  logic                    bus_ready
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] own;
  logic [PTR_W-1:0] own_next;
  logic [PTR_W-1:0] win_idx;
  logic [N_REQ-1:0] win;
  logic             any;
  logic             can_load;
  logic             own_req;
  logic             xfer;
  logic             burst_done;
  logic             release_own;
  logic [DATA_W-1:0] own_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // gnt is zero outside ARB_GRANT, so ack needs no separate state qualifier.
  assign can_load = !bus_valid || bus_ready;
  assign ack      = gnt & req & {N_REQ{can_load}};
  assign xfer     = |ack;
  assign own_req  = |(gnt & req);

  always_comb begin
    own_data = '0;
    win_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      own_data = own_data | (data_in[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
      if (win[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  assign own_next = (own == PTR_W'(N_REQ - 1)) ? '0 : own + PTR_W'(1);

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] beat_cnt;

  assign burst_done = xfer && (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_max_burst;

  assign burst_done       = 1'b0;
  assign unused_max_burst = 32'(MAX_BURST);
`endif

  assign release_own = (state == ARB_GRANT) && (!own_req || burst_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      ptr   <= '0;
      own   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any) begin
            gnt   <= win;
            own   <= win_idx;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_own) begin
            gnt   <= '0;
            ptr   <= own_next;
            state <= ARB_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Output stage runs independently of the FSM so a held beat drains after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else if (xfer) begin
      bus_out   <= own_data;
      bus_valid <= 1'b1;
    end else if (bus_valid && bus_ready) begin
      bus_valid <= 1'b0;
    end
  end

endmodule : bus_arbiter
`default_nettype wire
